// File: rtl/uart_rx_packer.sv
// uart_rx_packer: collects NUM_WORDS received UART words into one wide beat,
// tags the final beat of every BEATS_PER_FRAME-beat frame, and queues beats in
// a 2-entry output FIFO. If a beat completes while the FIFO is full and
// nothing is popping, that beat is dropped and a sticky overflow flag is raised.
module uart_rx_packer #(
  parameter int W_IN            = 16,
  parameter int NUM_WORDS       = 4,
  parameter int BEATS_PER_FRAME = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      s_valid,
  input  logic [W_IN-1:0]           s_data,
  input  logic                      m_ready,
  output logic                      m_valid,
  output logic [W_IN*NUM_WORDS-1:0] m_data,
  output logic                      m_last,
  output logic                      overflow
);

  localparam int BEAT_W = W_IN * NUM_WORDS;
  // The last word never needs storing: it is taken straight from s_data.
  localparam int ASM_W  = W_IN * (NUM_WORDS - 1);
  localparam int WC_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BC_W   = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;

  localparam logic [WC_W-1:0] WC_LAST   = WC_W'(NUM_WORDS - 1);
  localparam logic [BC_W-1:0] BC_LAST   = BC_W'(BEATS_PER_FRAME - 1);
  localparam logic [1:0]      OCC_EMPTY = 2'd0;
  localparam logic [1:0]      OCC_FULL  = 2'd2;

  // Word assembly state
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [ASM_W-1:0]  asm_q, asm_d;

  // Frame tracking and sticky error
  logic [BC_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic              overflow_q, overflow_d;

  // Output FIFO storage and bookkeeping
  logic [BEAT_W-1:0] fifo_data_q [2];
  logic [BEAT_W-1:0] fifo_data_d [2];
  logic              fifo_last_q [2];
  logic              fifo_last_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  // Handshake qualifiers
  logic              beat_done;
  logic              fifo_full;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic [BEAT_W-1:0] beat_full;
  logic              beat_is_last;

  assign beat_done    = s_valid && (word_cnt_q == WC_LAST);
  assign fifo_full    = (occ_q == OCC_FULL);
  assign pop          = m_valid && m_ready;
  // A same-cycle pop frees the slot the completing beat needs.
  assign push_ok      = beat_done && (!fifo_full || pop);
  assign drop         = beat_done && fifo_full && !pop;
  assign beat_full    = {s_data, asm_q};
  assign beat_is_last = (beat_cnt_q == BC_LAST);

  // Outputs come straight from registered FIFO state, never from s_*.
  assign m_valid  = (occ_q != OCC_EMPTY);
  assign m_data   = fifo_data_q[rd_ptr_q];
  assign m_last   = fifo_last_q[rd_ptr_q];
  assign overflow = overflow_q;

  // Word counter and assembly register: capture each non-final word into its slice.
  always_comb begin
    word_cnt_d = word_cnt_q;
    asm_d      = asm_q;
    if (s_valid) begin
      for (int k = 0; k < NUM_WORDS - 1; k++) begin
        if (word_cnt_q == WC_W'(k)) begin
          asm_d[k*W_IN +: W_IN] = s_data;
        end
      end
      if (word_cnt_q == WC_LAST) begin
        word_cnt_d = '0;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  // Beat counter and overflow: the frame position only moves when a beat is kept.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    overflow_d = overflow_q | drop;
    if (push_ok) begin
      if (beat_is_last) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // FIFO write/read pointers, storage and occupancy.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    if (push_ok) begin
      fifo_data_d[wr_ptr_q] = beat_full;
      fifo_last_d[wr_ptr_q] = beat_is_last;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset clears data too so outputs read zero during reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_cnt_q     <= '0;
      asm_q          <= '0;
      beat_cnt_q     <= '0;
      overflow_q     <= 1'b0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      occ_q          <= OCC_EMPTY;
    end else begin
      word_cnt_q     <= word_cnt_d;
      asm_q          <= asm_d;
      beat_cnt_q     <= beat_cnt_d;
      overflow_q     <= overflow_d;
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
      fifo_last_q[0] <= fifo_last_d[0];
      fifo_last_q[1] <= fifo_last_d[1];
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      occ_q          <= occ_d;
    end
  end

endmodule
